// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage core's hazard unit, EXE operand muxes and stage registers.
package pipe_pkg;

   localparam int RA_W_DEF = 4;

   // EXE operand source select
   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   // Default-width view of one in-flight instruction as tracked by the hazard unit
   typedef struct packed {
      logic                valid;
      logic [RA_W_DEF-1:0] rd;
      logic                rwrite;
      logic                is_load;
      logic [RA_W_DEF-1:0] rs1;
      logic [RA_W_DEF-1:0] rs2;
      logic                rs1_used;
      logic                rs2_used;
   } stage_info_t;

endpackage

// File: rtl/pipe_shadow_stage.sv
// One shadow pipeline register: cleared on reset, frozen on hold, loads empty on bubble.
module pipe_shadow_stage
   import pipe_pkg::*;
#(
   parameter type info_t = logic [7:0]
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  hold,
   input  logic  bubble,
   input  info_t d,
   output info_t q
);

   // register update: hold has precedence, a bubble inserts an all-zero (invalid) entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (!hold) begin
         q <= bubble ? info_t'('0) : d;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / forwarding controller: shadow EX/MEM/WB tracking, forward selects,
// load-use and interlock stalls, branch flush, memory-wait hold, perf counters.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int RA_W           = 4,
   parameter int FWD_EN         = 1,
   parameter int REGFILE_BYPASS = 1,
   parameter int REG_ZERO_HARD  = 0,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_rwrite,
   input  logic             id_is_load,
   input  logic             id_branch_taken,
   input  logic             mem_wait,
   output logic             stall_if,
   output logic             bubble_ex,
   output logic             flush_if,
   output logic             hold_all,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // same layout as stage_info_t, sized by this instance's RA_W
   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
      logic            rwrite;
      logic            is_load;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic            rs1_used;
      logic            rs2_used;
   } shadow_t;

   shadow_t id_info, ex_s, mem_s, wb_s;
   logic    load_use, raw_il, stall_id;

   function automatic logic hit(input shadow_t p, input logic [RA_W-1:0] s, input logic used);
      return p.valid & p.rwrite & (p.rd == s) & used
             & ~((REG_ZERO_HARD != 0) & (s == '0));
   endfunction

   function automatic logic hit_any_src(input shadow_t p);
      return hit(p, id_rs1, id_rs1_used) | hit(p, id_rs2, id_rs2_used);
   endfunction

   // younger producer (MEM) wins over older (WB)
   function automatic fwd_sel_e pick(input shadow_t m, input shadow_t w,
                                     input logic [RA_W-1:0] s, input logic used);
      if (FWD_EN == 0)      return FWD_RF;
      if (hit(m, s, used))  return FWD_EXMEM;
      if (hit(w, s, used))  return FWD_MEMWB;
      return FWD_RF;
   endfunction

   // pack the decode instruction into shadow form
   always_comb begin
      id_info          = '0;
      id_info.valid    = id_valid;
      id_info.rd       = id_rd;
      id_info.rwrite   = id_rwrite;
      id_info.is_load  = id_is_load;
      id_info.rs1      = id_rs1;
      id_info.rs2      = id_rs2;
      id_info.rs1_used = id_rs1_used;
      id_info.rs2_used = id_rs2_used;
   end

   // stall / bubble / flush / hold decisions; reset forces all of them low at once
   always_comb begin
      load_use = 1'b0;
      raw_il   = 1'b0;
      if (FWD_EN != 0) begin
         load_use = id_valid & ex_s.is_load & hit_any_src(ex_s);
      end else begin
         raw_il = id_valid & (hit_any_src(ex_s) | hit_any_src(mem_s)
                              | ((REGFILE_BYPASS == 0) & hit_any_src(wb_s)));
      end
      hold_all  = reset & mem_wait;
      stall_id  = hold_all | (reset & (load_use | raw_il));
      stall_if  = stall_id;
      bubble_ex = stall_id & ~hold_all;
      flush_if  = reset & id_valid & id_branch_taken & ~stall_id;
   end

   // EX-stage operand forward selects
   always_comb begin
      fwd_a = pick(mem_s, wb_s, ex_s.rs1, ex_s.rs1_used);
      fwd_b = pick(mem_s, wb_s, ex_s.rs2, ex_s.rs2_used);
   end

   pipe_shadow_stage #(.info_t(shadow_t)) u_ex (
      .clk    (clk),
      .reset  (reset),
      .hold   (hold_all),
      .bubble (bubble_ex),
      .d      (id_info),
      .q      (ex_s)
   );

   pipe_shadow_stage #(.info_t(shadow_t)) u_mem (
      .clk    (clk),
      .reset  (reset),
      .hold   (hold_all),
      .bubble (1'b0),
      .d      (ex_s),
      .q      (mem_s)
   );

   pipe_shadow_stage #(.info_t(shadow_t)) u_wb (
      .clk    (clk),
      .reset  (reset),
      .hold   (hold_all),
      .bubble (1'b0),
      .d      (mem_s),
      .q      (wb_s)
   );

   // saturating stall / flush cycle counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush_if && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: four configurations share one stimulus stream.
//   c0 forwarding, c1 forwarding + hard r0, c2 interlock + bypass, c3 interlock no bypass (3-bit counters)
module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic       v;
      logic [3:0] rd;
      logic       rw;
      logic       ld;
      logic [3:0] rs1;
      logic       u1;
      logic [3:0] rs2;
      logic       u2;
      logic       br;
      logic       mw;
   } in_t;

   typedef struct packed {
      logic       stall;
      logic       bubble;
      logic       flush;
      logic       hold;
      logic [1:0] fa;
      logic [1:0] fb;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   // one in-flight instruction, as the model remembers it
   typedef struct packed {
      logic       v;
      logic [3:0] rd;
      logic       rw;
      logic       ld;
      logic [3:0] rs1;
      logic       u1;
      logic [3:0] rs2;
      logic       u2;
   } fl_t;

   logic        clk, reset;
   logic        id_valid, id_rs1_used, id_rs2_used, id_rwrite, id_is_load, id_branch_taken, mem_wait;
   logic [3:0]  id_rs1, id_rs2, id_rd;
   logic        stall_if[4], bubble_ex[4], flush_if[4], hold_all[4];
   logic [1:0]  fwd_a[4], fwd_b[4];
   logic [15:0] scnt0, fcnt0, scnt1, fcnt1, scnt2, fcnt2;
   logic [2:0]  scnt3, fcnt3;

   int   total = 0;
   int   bad   = 0;
   in_t  cur;
   fl_t  fl[4][3];   // [config][age]: 0 = in EX, 1 = in MEM, 2 = in WB
   int   scnt_m[4], fcnt_m[4];
   vec_t tbl[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FWD_EN(1), .REGFILE_BYPASS(1), .REG_ZERO_HARD(0), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rwrite(id_rwrite),
      .id_is_load(id_is_load), .id_branch_taken(id_branch_taken), .mem_wait(mem_wait),
      .stall_if(stall_if[0]), .bubble_ex(bubble_ex[0]), .flush_if(flush_if[0]), .hold_all(hold_all[0]),
      .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall_cnt(scnt0), .flush_cnt(fcnt0));

   pipe_hazard_ctrl #(.FWD_EN(1), .REGFILE_BYPASS(1), .REG_ZERO_HARD(1), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rwrite(id_rwrite),
      .id_is_load(id_is_load), .id_branch_taken(id_branch_taken), .mem_wait(mem_wait),
      .stall_if(stall_if[1]), .bubble_ex(bubble_ex[1]), .flush_if(flush_if[1]), .hold_all(hold_all[1]),
      .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall_cnt(scnt1), .flush_cnt(fcnt1));

   pipe_hazard_ctrl #(.FWD_EN(0), .REGFILE_BYPASS(1), .REG_ZERO_HARD(0), .CNT_W(16)) dut2 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rwrite(id_rwrite),
      .id_is_load(id_is_load), .id_branch_taken(id_branch_taken), .mem_wait(mem_wait),
      .stall_if(stall_if[2]), .bubble_ex(bubble_ex[2]), .flush_if(flush_if[2]), .hold_all(hold_all[2]),
      .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .stall_cnt(scnt2), .flush_cnt(fcnt2));

   pipe_hazard_ctrl #(.FWD_EN(0), .REGFILE_BYPASS(0), .REG_ZERO_HARD(0), .CNT_W(3)) dut3 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rwrite(id_rwrite),
      .id_is_load(id_is_load), .id_branch_taken(id_branch_taken), .mem_wait(mem_wait),
      .stall_if(stall_if[3]), .bubble_ex(bubble_ex[3]), .flush_if(flush_if[3]), .hold_all(hold_all[3]),
      .fwd_a(fwd_a[3]), .fwd_b(fwd_b[3]), .stall_cnt(scnt3), .flush_cnt(fcnt3));

   function automatic in_t mk_in(bit v, int rd, bit rw, bit ld, int rs1, bit u1,
                                 int rs2, bit u2, bit br, bit mw);
      in_t x;
      x.v = v; x.rd = 4'(rd); x.rw = rw; x.ld = ld; x.rs1 = 4'(rs1); x.u1 = u1;
      x.rs2 = 4'(rs2); x.u2 = u2; x.br = br; x.mw = mw;
      return x;
   endfunction

   function automatic out_t mk_out(bit st, bit bu, bit fl, bit ho, int fa, int fb);
      out_t o;
      o.stall = st; o.bubble = bu; o.flush = fl; o.hold = ho; o.fa = 2'(fa); o.fb = 2'(fb);
      return o;
   endfunction

   task automatic add_row(input in_t i, input out_t o);
      vec_t r;
      r.i = i; r.o = o;
      tbl.push_back(r);
   endtask

   task automatic drive(input in_t x);
      cur             = x;
      id_valid        = x.v;
      id_rd           = x.rd;
      id_rwrite       = x.rw;
      id_is_load      = x.ld;
      id_rs1          = x.rs1;
      id_rs1_used     = x.u1;
      id_rs2          = x.rs2;
      id_rs2_used     = x.u2;
      id_branch_taken = x.br;
      mem_wait        = x.mw;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", nm, got, exp, $time);
      end
   endtask

   function automatic out_t act(int c);
      out_t o;
      o.stall = stall_if[c]; o.bubble = bubble_ex[c]; o.flush = flush_if[c];
      o.hold = hold_all[c]; o.fa = fwd_a[c]; o.fb = fwd_b[c];
      return o;
   endfunction

   function automatic int act_scnt(int c);
      case (c)
         0: return int'(scnt0);
         1: return int'(scnt1);
         2: return int'(scnt2);
         default: return int'(scnt3);
      endcase
   endfunction

   function automatic int act_fcnt(int c);
      case (c)
         0: return int'(fcnt0);
         1: return int'(fcnt1);
         2: return int'(fcnt2);
         default: return int'(fcnt3);
      endcase
   endfunction

   task automatic cmp_out(input string pre, input out_t a, input out_t e);
      chk({pre, ".stall_if"},  32'(a.stall),  32'(e.stall));
      chk({pre, ".bubble_ex"}, 32'(a.bubble), 32'(e.bubble));
      chk({pre, ".flush_if"},  32'(a.flush),  32'(e.flush));
      chk({pre, ".hold_all"},  32'(a.hold),   32'(e.hold));
      chk({pre, ".fwd_a"},     32'(a.fa),     32'(e.fa));
      chk({pre, ".fwd_b"},     32'(a.fb),     32'(e.fb));
   endtask

   // ---------------- reference model ----------------
   function automatic bit writes(fl_t p, logic [3:0] s, logic used, bit rz);
      return p.v && p.rw && (p.rd == s) && used && !(rz && s == 4'd0);
   endfunction

   function automatic logic [1:0] fwd_of(int c, logic [3:0] s, logic used);
      // nearest older producer in MEM (age 1 -> 01) or WB (age 2 -> 10)
      for (int k = 1; k <= 2; k++)
         if (writes(fl[c][k], s, used, c == 1)) return 2'(k);
      return 2'd0;
   endfunction

   function automatic out_t model(int c, in_t x);
      out_t o;
      bit   fwd  = (c < 2);
      bit   rz   = (c == 1);
      int   last = (c == 3) ? 2 : 1;   // oldest stage still blocking without forwarding
      bit   dep  = 1'b0;
      o = '0;
      if (fwd) begin
         o.fa = fwd_of(c, fl[c][0].rs1, fl[c][0].u1);
         o.fb = fwd_of(c, fl[c][0].rs2, fl[c][0].u2);
         dep  = x.v && fl[c][0].ld &&
                (writes(fl[c][0], x.rs1, x.u1, rz) || writes(fl[c][0], x.rs2, x.u2, rz));
      end else begin
         for (int k = 0; k <= last; k++)
            if (writes(fl[c][k], x.rs1, x.u1, rz) || writes(fl[c][k], x.rs2, x.u2, rz))
               dep = x.v;
      end
      o.hold   = x.mw;
      o.stall  = x.mw || dep;
      o.bubble = o.stall && !o.hold;
      o.flush  = x.v && x.br && !o.stall;
      return o;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 3; k++) fl[c][k] = '0;
         scnt_m[c] = 0;
         fcnt_m[c] = 0;
      end
   endtask

   task automatic model_advance();
      for (int c = 0; c < 4; c++) begin
         out_t o   = model(c, cur);
         int   top = (c == 3) ? 7 : 65535;
         fl_t  nw;
         if (o.stall && scnt_m[c] < top) scnt_m[c]++;
         if (o.flush && fcnt_m[c] < top) fcnt_m[c]++;
         if (!o.hold) begin
            nw = '{v: cur.v, rd: cur.rd, rw: cur.rw, ld: cur.ld,
                   rs1: cur.rs1, u1: cur.u1, rs2: cur.rs2, u2: cur.u2};
            fl[c][2] = fl[c][1];
            fl[c][1] = fl[c][0];
            fl[c][0] = o.bubble ? fl_t'('0) : nw;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      drive('0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   in_t nop_i, add_r1, add_r2_r1;

   initial begin
      nop_i     = '0;
      add_r1    = mk_in(1, 1, 1, 0, 2, 1, 3, 1, 0, 0);
      add_r2_r1 = mk_in(1, 2, 1, 0, 1, 1, 1, 1, 0, 0);

      // forwarding config directed trace: back-to-back ALU, load-use, branch, mem wait
      add_row(add_r1,                                  mk_out(0, 0, 0, 0, 0, 0));
      add_row(add_r2_r1,                               mk_out(0, 0, 0, 0, 0, 0));
      add_row(nop_i,                                   mk_out(0, 0, 0, 0, 1, 1));
      add_row(mk_in(1, 3, 1, 1, 4, 1, 0, 0, 0, 0),     mk_out(0, 0, 0, 0, 0, 0));
      add_row(mk_in(1, 4, 1, 0, 3, 1, 5, 1, 0, 0),     mk_out(1, 1, 0, 0, 0, 0));
      add_row(mk_in(1, 4, 1, 0, 3, 1, 5, 1, 0, 0),     mk_out(0, 0, 0, 0, 0, 0));
      add_row(nop_i,                                   mk_out(0, 0, 0, 0, 2, 0));
      add_row(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0),     mk_out(0, 0, 1, 0, 0, 0));
      add_row(mk_in(1, 6, 1, 1, 7, 1, 0, 0, 0, 0),     mk_out(0, 0, 0, 0, 0, 0));
      add_row(mk_in(1, 0, 0, 0, 6, 1, 0, 0, 1, 0),     mk_out(1, 1, 0, 0, 0, 0));
      add_row(mk_in(1, 0, 0, 0, 6, 1, 0, 0, 1, 0),     mk_out(0, 0, 1, 0, 0, 0));
      add_row(mk_in(1, 8, 1, 1, 9, 1, 0, 0, 0, 0),     mk_out(0, 0, 0, 0, 2, 0));
      add_row(mk_in(1, 9, 1, 0, 8, 1, 1, 1, 0, 0),     mk_out(1, 1, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++)
         add_row(mk_in(1, 9, 1, 0, 8, 1, 1, 1, 0, 1),  mk_out(1, 0, 0, 1, 0, 0));
      add_row(mk_in(1, 9, 1, 0, 8, 1, 1, 1, 0, 0),     mk_out(0, 0, 0, 0, 0, 0));
      add_row(nop_i,                                   mk_out(0, 0, 0, 0, 2, 0));

      // reset state, with inputs that would otherwise raise hold/flush
      reset = 1'b0;
      drive(mk_in(1, 1, 1, 1, 1, 1, 1, 1, 1, 1));
      model_clear();
      #2;
      cmp_out("reset", act(0), '0);
      chk("reset.stall_cnt", 32'(act_scnt(0)), 0);
      chk("reset.flush_cnt", 32'(act_fcnt(0)), 0);
      apply_reset();

      // table
      for (int r = 0; r < tbl.size(); r++) begin
         drive(tbl[r].i);
         @(negedge clk);
         cmp_out($sformatf("row%0d", r), act(0), tbl[r].o);
         tick();
      end
      chk("tbl.stall_cnt", 32'(act_scnt(0)), 6);
      chk("tbl.flush_cnt", 32'(act_fcnt(0)), 2);

      // r0 producer: hard zero never forwards, normal r0 forwards from EX/MEM
      apply_reset();
      drive(mk_in(1, 0, 1, 0, 2, 1, 3, 1, 0, 0));
      tick();
      drive(mk_in(1, 1, 1, 0, 0, 1, 0, 1, 0, 0));
      @(negedge clk);
      chk("r0.c0.stall", 32'(stall_if[0]), 0);
      chk("r0.c1.stall", 32'(stall_if[1]), 0);
      tick();
      drive(nop_i);
      @(negedge clk);
      chk("r0.hard.fwd_a", 32'(fwd_a[1]), 0);
      chk("r0.hard.fwd_b", 32'(fwd_b[1]), 0);
      chk("r0.soft.fwd_a", 32'(fwd_a[0]), 1);
      chk("r0.soft.fwd_b", 32'(fwd_b[0]), 1);
      tick();

      // interlock with bypass: two stall cycles, async reset during the second
      apply_reset();
      drive(add_r1);
      @(negedge clk);
      chk("il.c0.stall", 32'(stall_if[2]), 0);
      tick();
      drive(add_r2_r1);
      @(negedge clk);
      chk("il.c1.stall",  32'(stall_if[2]),  1);
      chk("il.c1.bubble", 32'(bubble_ex[2]), 1);
      chk("il.c1.fwd_a",  32'(fwd_a[2]),     0);
      tick();
      @(negedge clk);
      chk("il.c2.stall",  32'(stall_if[2]),  1);
      chk("il.c2.bubble", 32'(bubble_ex[2]), 1);
      chk("il.c2.cnt",    32'(act_scnt(2)),  1);
      #1 reset = 1'b0;
      #1;
      chk("il.rst.stall",  32'(stall_if[2]),  0);
      chk("il.rst.bubble", 32'(bubble_ex[2]), 0);
      chk("il.rst.cnt",    32'(act_scnt(2)),  0);
      chk("il.rst.c3cnt",  32'(act_scnt(3)),  0);
      apply_reset();
      drive(add_r2_r1);
      @(negedge clk);
      chk("il.post.stall", 32'(stall_if[2]), 0);
      tick();
      apply_reset();

      // random traffic against the model, all four configurations
      for (int n = 0; n < 600; n++) begin
         drive(mk_in($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 7) == 0));
         @(negedge clk);
         for (int c = 0; c < 4; c++) begin
            cmp_out($sformatf("rnd%0d.c%0d", n, c), act(c), model(c, cur));
            chk($sformatf("rnd%0d.c%0d.stall_cnt", n, c), 32'(act_scnt(c)), 32'(scnt_m[c]));
            chk($sformatf("rnd%0d.c%0d.flush_cnt", n, c), 32'(act_fcnt(c)), 32'(fcnt_m[c]));
         end
         tick();
      end
      chk("sat.c3.stall_cnt", 32'(act_scnt(3)), 32'(scnt_m[3]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
